// File: rtl/io_bus_pkg.sv
// Shared constants for the memory-mapped I/O responder:
// register offsets, FSM state encoding and STATUS bit positions.
package io_bus_pkg;

   localparam logic [3:0] OFF_OUT    = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h1;
   localparam logic [3:0] OFF_IN     = 4'h2;
   localparam logic [3:0] OFF_TIMER  = 4'h3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RESP      = 2'd1,
      WAIT_FULL = 2'd2
   } io_state_t;

   localparam int ST_FULL   = 0;
   localparam int ST_EMPTY  = 1;
   localparam int ST_PEND   = 2;
   localparam int ST_OVR    = 3;
   localparam int ST_CNT_LO = 4;
   localparam int ST_CNT_HI = 8;

endpackage

// File: rtl/io_bus_responder_if.sv
// Data-memory bus as seen by an I/O target: request strobe,
// address/data from the control unit, registered reply and ready.
interface io_bus_responder_if #(
   parameter int DATA_W = 16
);

   logic              mem_e;
   logic              mem_w;
   logic [15:0]       mem_address;
   logic [DATA_W-1:0] mem_in;
   logic [DATA_W-1:0] mem_out;
   logic              io_sel;
   logic              io_ready;

   modport master (
      output mem_e, mem_w, mem_address, mem_in,
      input  mem_out, io_sel, io_ready
   );

   modport slave (
      input  mem_e, mem_w, mem_address, mem_in,
      output mem_out, io_sel, io_ready
   );

endinterface

// File: rtl/io_bus_responder_fifo.sv
// sync_fifo_16: power-of-two synchronous FIFO with occupancy count
// and a head output that reads as zero while empty.
module sync_fifo_16 #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [W-1:0]           head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = cnt;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are AW bits wide, so wrap is the natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O target: output FIFO, input holding register and
// an optional free-running timer (enabled by defining IO_TIMER_EN).
module io_bus_responder
   import io_bus_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'hFF00,
   parameter int          FIFO_DEPTH = 4,
   parameter int          DATA_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   io_bus_responder_if.slave bus,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ack,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   io_state_t         state;
   logic [DATA_W-1:0] mem_out_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] timer_val;

   logic              hit;
   logic              accept;
   logic [3:0]        off;
   logic              rd_status;
   logic              rd_in;

   logic              fifo_push;
   logic [DATA_W-1:0] fifo_wdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;

   logic [DATA_W-1:0] in_word;
   logic              in_pending;
   logic              overrun;

   assign off    = bus.mem_address[3:0];
   assign hit    = bus.mem_e &
                   (bus.mem_address[15:4] == BASE_ADDR[15:4]);
   assign accept = hit & (state == IDLE);

   assign bus.io_sel   = hit;
   assign bus.io_ready = (state == RESP);
   assign bus.mem_out  = mem_out_q;

   assign rd_status = accept & ~bus.mem_w & (off == OFF_STATUS);
   assign rd_in     = accept & ~bus.mem_w & (off == OFF_IN);

   // A stalled OUT write is retried from the captured word.
   assign fifo_push = (state == WAIT_FULL) ? ~fifo_full
                    : accept & bus.mem_w & (off == OFF_OUT) & ~fifo_full;
   assign fifo_wdata = (state == WAIT_FULL) ? wdata_q : bus.mem_in;
   assign out_valid  = ~fifo_empty;

   sync_fifo_16 #(
      .DEPTH (FIFO_DEPTH),
      .W     (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (out_ack),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (out_data)
   );

   always_comb begin
      status = '0;
      status[ST_FULL]  = fifo_full;
      status[ST_EMPTY] = fifo_empty;
      status[ST_PEND]  = in_pending;
      status[ST_OVR]   = overrun;
      status[ST_CNT_HI:ST_CNT_LO] = 5'(fifo_count);
   end

   always_comb begin
      rdata = '0;
      case (off)
         OFF_STATUS: rdata = status;
         OFF_IN:     rdata = in_word;
         OFF_TIMER:  rdata = timer_val;
         default:    rdata = '0;
      endcase
   end

`ifdef IO_TIMER_EN
   logic [DATA_W-1:0] timer;
   logic              wr_timer;

   assign wr_timer  = accept & bus.mem_w & (off == OFF_TIMER);
   assign timer_val = timer;

   // The load counts in the same edge, so the next cycle sees mem_in + 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
      end else if (wr_timer) begin
         timer <= bus.mem_in + DATA_W'(1);
      end else begin
         timer <= timer + DATA_W'(1);
      end
   end
`else
   assign timer_val = '0;
`endif

   // A word arriving with an IN read is kept; the read consumed the old one.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_word    <= '0;
         in_pending <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (in_valid) begin
            in_word    <= in_data;
            in_pending <= 1'b1;
         end else if (rd_in) begin
            in_pending <= 1'b0;
         end
         if (rd_status) overrun <= 1'b0;
         if (in_valid & in_pending & ~rd_in) overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_out_q <= '0;
         wdata_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (hit) begin
                  wdata_q <= bus.mem_in;
                  if (bus.mem_w & (off == OFF_OUT) & fifo_full) begin
                     state <= WAIT_FULL;
                  end else begin
                     state     <= RESP;
                     mem_out_q <= bus.mem_w ? '0 : rdata;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
            end
            WAIT_FULL: begin
               if (~fifo_full) begin
                  state     <= RESP;
                  mem_out_q <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder; expected timer value follows
// whether IO_TIMER_EN is defined for the build.
module tb_io_bus_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ack;
   logic [15:0] in_data;
   logic        in_valid;

   int total = 0;
   int bad   = 0;

   io_bus_responder_if bus ();

   io_bus_responder dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .in_data   (in_data),
      .in_valid  (in_valid)
   );

   always #5 clk = ~clk;

`ifdef IO_TIMER_EN
   localparam logic [15:0] EXP_TIMER = 16'h0001;
`else
   localparam logic [15:0] EXP_TIMER = 16'h0000;
`endif

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.mem_e       = 1'b0;
      bus.mem_w       = 1'b0;
      bus.mem_address = '0;
      bus.mem_in      = '0;
      out_ack         = 1'b0;
      in_valid        = 1'b0;
      in_data         = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Starts and ends on a falling edge; ready is due one cycle later.
   task automatic access(input string tag, input logic w,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp);
      bus.mem_e       = 1'b1;
      bus.mem_w       = w;
      bus.mem_address = a;
      bus.mem_in      = d;
      @(negedge clk);
      chk({tag, "_rdy"}, bus.io_ready, 1'b1);
      if (!w) chk(tag, bus.mem_out, exp);
      bus.mem_e = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_in(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic fill4();
      access("w1", 1'b1, 16'hFF00, 16'h1111, 16'h0);
      access("w2", 1'b1, 16'hFF00, 16'h2222, 16'h0);
      access("w3", 1'b1, 16'hFF00, 16'h3333, 16'h0);
      access("w4", 1'b1, 16'hFF00, 16'h4444, 16'h0);
   endtask

   logic [15:0] drain [4];

   initial begin
      drain[0] = 16'h2222;
      drain[1] = 16'h3333;
      drain[2] = 16'h4444;
      drain[3] = 16'hBEEF;

      do_reset();
      chk("rst_mem_out", bus.mem_out, 16'h0);
      chk("rst_ready", bus.io_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 16'h0);

      // single push, then STATUS with one held input word
      access("wr_out", 1'b1, 16'hFF00, 16'h1234, 16'h0);
      chk("push_valid", out_valid, 1'b1);
      chk("push_data", out_data, 16'h1234);
      pulse_in(16'h00AA);
      access("status1", 1'b0, 16'hFF01, 16'h0, 16'h0014);
      access("rd_out_reg", 1'b0, 16'hFF00, 16'h0, 16'h0000);

      // back-pressure on a full FIFO
      do_reset();
      fill4();
      access("status_full", 1'b0, 16'hFF01, 16'h0, 16'h0041);
      bus.mem_e       = 1'b1;
      bus.mem_w       = 1'b1;
      bus.mem_address = 16'hFF00;
      bus.mem_in      = 16'hBEEF;
      @(negedge clk);
      chk("wf_hold0", bus.io_ready, 1'b0);
      @(negedge clk);
      chk("wf_hold1", bus.io_ready, 1'b0);
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      chk("wf_hold2", bus.io_ready, 1'b0);
      chk("wf_head", out_data, 16'h2222);
      @(negedge clk);
      chk("wf_ready", bus.io_ready, 1'b1);
      bus.mem_e = 1'b0;
      @(negedge clk);
      access("status_refull", 1'b0, 16'hFF01, 16'h0, 16'h0041);
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", out_valid, 1'b1);
         chk("drain_data", out_data, drain[i]);
         out_ack = 1'b1;
         @(negedge clk);
         out_ack = 1'b0;
      end
      chk("drained_valid", out_valid, 1'b0);
      chk("drained_data", out_data, 16'h0);
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      access("status_empty", 1'b0, 16'hFF01, 16'h0, 16'h0002);

      // input register, overrun and its clear-on-read
      do_reset();
      pulse_in(16'h00AA);
      pulse_in(16'h00BB);
      access("status_ovr", 1'b0, 16'hFF01, 16'h0, 16'h000E);
      access("rd_in", 1'b0, 16'hFF02, 16'h0, 16'h00BB);
      access("status_clr", 1'b0, 16'hFF01, 16'h0, 16'h0002);

      // new word arriving together with an IN read
      pulse_in(16'h0011);
      bus.mem_e       = 1'b1;
      bus.mem_w       = 1'b0;
      bus.mem_address = 16'hFF02;
      in_valid        = 1'b1;
      in_data         = 16'h0022;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rd_in_coll", bus.mem_out, 16'h0011);
      bus.mem_e = 1'b0;
      @(negedge clk);
      access("status_coll", 1'b0, 16'hFF01, 16'h0, 16'h0006);
      access("rd_in_new", 1'b0, 16'hFF02, 16'h0, 16'h0022);

      // timer load and wrap
      do_reset();
      access("wr_timer", 1'b1, 16'hFF03, 16'hFFFE, 16'h0);
      @(negedge clk);
      access("rd_timer", 1'b0, 16'hFF03, 16'h0, EXP_TIMER);

      // unmapped offsets and misses
      do_reset();
      access("status_pre", 1'b0, 16'hFF01, 16'h0, 16'h0002);
      access("rd_unmapped", 1'b0, 16'hFF07, 16'h0, 16'h0000);
      access("wr_unmapped", 1'b1, 16'hFF09, 16'h5555, 16'h0);
      chk("wr_unmapped_fifo", out_valid, 1'b0);
      bus.mem_e       = 1'b1;
      bus.mem_w       = 1'b0;
      bus.mem_address = 16'hFF05;
      #1;
      chk("sel_hit", bus.io_sel, 1'b1);
      bus.mem_address = 16'h0100;
      #1;
      chk("sel_miss", bus.io_sel, 1'b0);
      @(negedge clk);
      chk("miss_rdy0", bus.io_ready, 1'b0);
      @(negedge clk);
      chk("miss_rdy1", bus.io_ready, 1'b0);
      bus.mem_e = 1'b0;
      @(negedge clk);

      // reset while stalled in WAIT_FULL
      do_reset();
      fill4();
      access("status_pre_rst", 1'b0, 16'hFF01, 16'h0, 16'h0041);
      bus.mem_e       = 1'b1;
      bus.mem_w       = 1'b1;
      bus.mem_address = 16'hFF00;
      bus.mem_in      = 16'hBEEF;
      @(negedge clk);
      chk("stall_rdy", bus.io_ready, 1'b0);
      rst       = 1'b1;
      bus.mem_e = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_mem_out", bus.mem_out, 16'h0);
      chk("mid_rst_ready", bus.io_ready, 1'b0);
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_data", out_data, 16'h0);
      @(negedge clk);
      chk("mid_rst_no_rdy", bus.io_ready, 1'b0);
      chk("mid_rst_dropped", out_valid, 1'b0);
      access("post_rst_status", 1'b0, 16'hFF01, 16'h0, 16'h0002);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
